// File: rtl/cpu_pkg.sv
// Shared CPU constants and the writeback result record.
// Used by wb_unit, wb_fifo and wb_unit_if.
package cpu_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 12;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Addresses NUM_REGS and above have no backing register.
    function automatic logic is_legal(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NUM_REGS);
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Writeback bus: ALU/memory result streams, issue/query and register-file write port.
// Macro WB_BYPASS_EN adds the forwarding outputs.
interface wb_unit_if;
    import cpu_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic [ADDR_W-1:0] q_a1;
    logic [ADDR_W-1:0] q_a2;
    logic              q_busy1;
    logic              q_busy2;
    logic              wre;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic              illegal_addr;
`ifdef WB_BYPASS_EN
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        output issue_valid, issue_rd, q_a1, q_a2,
        input  alu_ready, q_busy1, q_busy2, wre, a3, wd3, illegal_addr
`ifdef WB_BYPASS_EN
        , input fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
        input  issue_valid, issue_rd, q_a1, q_a2,
        output alu_ready, q_busy1, q_busy2, wre, a3, wd3, illegal_addr
`ifdef WB_BYPASS_EN
        , output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
`endif
    );

endinterface

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO of writeback entries buffering back-pressured ALU results.
// Head entry is visible combinationally so the arbiter can pop it in the same cycle.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  wb_entry_t        i_din,
    input  logic             i_pop,
    output wb_entry_t        o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage carries no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (i_pop && !i_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: arbitrates load data and ALU results onto the register-file write
// port and tracks pending writes. Macro WB_BYPASS_EN enables same-cycle forwarding.
module wb_unit
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    wb_unit_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t          w_alu_ent;
    wb_entry_t          w_mem_ent;
    wb_entry_t          w_head;
    wb_entry_t          w_win;
    logic               w_win_valid;
    logic               w_win_legal;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_alu_acc;
    logic               w_push;
    logic               w_pop;
    logic [NUM_REGS-1:0] w_pend_next;
    logic               w_busy1;
    logic               w_busy2;

    logic               r_wre;
    logic [ADDR_W-1:0]  r_a3;
    logic [DATA_W-1:0]  r_wd3;
    logic               r_illegal;
    logic [NUM_REGS-1:0] r_pending;

    assign w_alu_ent     = '{rd: bus.alu_rd, data: bus.alu_data};
    assign w_mem_ent     = '{rd: bus.mem_rd, data: bus.mem_data};
    assign bus.alu_ready = (w_count != CNT_W'(FIFO_DEPTH));
    assign w_alu_acc     = bus.alu_valid && bus.alu_ready;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_alu_ent),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    // Loads never stall, so they win; buffered ALU results drain before new ones.
    always_comb begin
        w_win       = w_mem_ent;
        w_win_valid = 1'b1;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        if (bus.mem_valid) begin
            w_push = w_alu_acc && !w_fifo_full;
        end else if (!w_fifo_empty) begin
            w_win  = w_head;
            w_pop  = 1'b1;
            w_push = w_alu_acc;
        end else if (w_alu_acc) begin
            w_win = w_alu_ent;
        end else begin
            w_win_valid = 1'b0;
        end
    end

    assign w_win_legal = is_legal(w_win.rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wre     <= 1'b0;
            r_a3      <= '0;
            r_wd3     <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_wre     <= w_win_valid && w_win_legal;
            r_illegal <= w_win_valid && !w_win_legal;
            if (w_win_valid && w_win_legal) begin
                r_a3  <= w_win.rd;
                r_wd3 <= w_win.data;
            end
        end
    end

    // A new issue to the register being committed keeps it pending.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            assign w_pend_next[gi] =
                (bus.issue_valid && bus.issue_rd == ADDR_W'(gi)) ||
                (r_pending[gi] && !(r_wre && r_a3 == ADDR_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_next;
        end
    end

    assign w_busy1 = is_legal(bus.q_a1) ? r_pending[bus.q_a1] : 1'b0;
    assign w_busy2 = is_legal(bus.q_a2) ? r_pending[bus.q_a2] : 1'b0;

`ifdef WB_BYPASS_EN
    assign bus.fwd_hit1  = r_wre && (r_a3 == bus.q_a1) && is_legal(bus.q_a1);
    assign bus.fwd_hit2  = r_wre && (r_a3 == bus.q_a2) && is_legal(bus.q_a2);
    assign bus.fwd_data1 = r_wd3;
    assign bus.fwd_data2 = r_wd3;
    assign bus.q_busy1   = w_busy1 && !bus.fwd_hit1;
    assign bus.q_busy2   = w_busy2 && !bus.fwd_hit2;
`else
    assign bus.q_busy1   = w_busy1;
    assign bus.q_busy2   = w_busy2;
`endif

    assign bus.wre          = r_wre;
    assign bus.a3           = r_a3;
    assign bus.wd3          = r_wd3;
    assign bus.illegal_addr = r_illegal;

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: per-cycle vector table plus a reset sequence,
// with an independent write-order model and pending-register model.
module tb_wb_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    wb_unit_if u_if ();

    wb_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] md;
        logic        av;
        logic [3:0]  ard;
        logic [15:0] ad;
        logic        iv;
        logic [3:0]  ird;
        logic [3:0]  q1;
        logic [3:0]  q2;
        logic        exp_ready;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Model state: expected outputs for the current cycle and accepted ALU results
    ent_t        alu_q[$];
    logic        exp_wre  = 1'b0;
    logic [3:0]  exp_a3   = '0;
    logic [15:0] exp_wd3  = '0;
    logic        exp_ill  = 1'b0;
    logic [11:0] pend     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [3:0] q);
        if (q >= 4'd12) return 1'b0;
`ifdef WB_BYPASS_EN
        if (exp_wre && exp_a3 == q) return 1'b0;
`endif
        return pend[q];
    endfunction

    // Write order: a load writes the next cycle; otherwise the oldest accepted ALU result.
    always @(posedge clk or negedge rst_n) begin : model
        ent_t win;
        logic win_v;
        if (!rst_n) begin
            alu_q.delete();
            exp_wre <= 1'b0;
            exp_a3  <= '0;
            exp_wd3 <= '0;
            exp_ill <= 1'b0;
            pend    <= '0;
        end else begin
            win_v = 1'b0;
            win   = '0;
            if (u_if.alu_valid && u_if.alu_ready)
                alu_q.push_back('{rd: u_if.alu_rd, d: u_if.alu_data});
            if (u_if.mem_valid) begin
                win_v = 1'b1;
                win   = '{rd: u_if.mem_rd, d: u_if.mem_data};
            end else if (alu_q.size() > 0) begin
                win_v = 1'b1;
                win   = alu_q.pop_front();
            end
            exp_wre <= win_v && (win.rd < 4'd12);
            exp_ill <= win_v && (win.rd >= 4'd12);
            if (win_v && win.rd < 4'd12) begin
                exp_a3  <= win.rd;
                exp_wd3 <= win.d;
            end
            for (int r = 0; r < 12; r++) begin
                if (u_if.issue_valid && u_if.issue_rd == 4'(r))
                    pend[r] <= 1'b1;
                else if (exp_wre && exp_a3 == 4'(r))
                    pend[r] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (u_if.wre)
            $display("write r%0d <= %h", u_if.a3, u_if.wd3);
        check("wre", u_if.wre, exp_wre);
        check("a3", u_if.a3, exp_a3);
        check("wd3", u_if.wd3, exp_wd3);
        check("illegal_addr", u_if.illegal_addr, exp_ill);
        check("q_busy1", u_if.q_busy1, m_busy(u_if.q_a1));
        check("q_busy2", u_if.q_busy2, m_busy(u_if.q_a2));
`ifdef WB_BYPASS_EN
        check("fwd_hit1", u_if.fwd_hit1, exp_wre && exp_a3 == u_if.q_a1 && u_if.q_a1 < 4'd12);
        check("fwd_hit2", u_if.fwd_hit2, exp_wre && exp_a3 == u_if.q_a2 && u_if.q_a2 < 4'd12);
        check("fwd_data1", u_if.fwd_data1, exp_wd3);
        check("fwd_data2", u_if.fwd_data2, exp_wd3);
`endif
    end

    task automatic drive(input vec_t v);
        u_if.mem_valid   = v.mv;
        u_if.mem_rd      = v.mrd;
        u_if.mem_data    = v.md;
        u_if.alu_valid   = v.av;
        u_if.alu_rd      = v.ard;
        u_if.alu_data    = v.ad;
        u_if.issue_valid = v.iv;
        u_if.issue_rd    = v.ird;
        u_if.q_a1        = v.q1;
        u_if.q_a2        = v.q2;
    endtask

    vec_t tbl [23];
    vec_t idle;

    initial begin
        //           mv mrd   md        av ard   ad        iv ird   q1    q2    rdy
        idle    = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd0, 1};
        tbl[0]  = '{0, 4'd0, 16'h0000, 1, 4'd3, 16'h1234, 0, 4'd0, 4'd3, 4'd0, 1};
        tbl[1]  = idle;
        tbl[2]  = '{1, 4'd5, 16'hAAAA, 1, 4'd6, 16'h5555, 0, 4'd0, 4'd5, 4'd6, 1};
        tbl[3]  = idle;
        tbl[4]  = '{1, 4'd1, 16'h1111, 1, 4'd2, 16'h2001, 0, 4'd0, 4'd1, 4'd2, 1};
        tbl[5]  = '{1, 4'd1, 16'h1112, 1, 4'd2, 16'h2002, 0, 4'd0, 4'd1, 4'd2, 1};
        tbl[6]  = '{1, 4'd1, 16'h1113, 1, 4'd2, 16'h2003, 0, 4'd0, 4'd1, 4'd2, 0};
        tbl[7]  = '{1, 4'd1, 16'h1114, 1, 4'd2, 16'h2003, 0, 4'd0, 4'd1, 4'd2, 0};
        tbl[8]  = '{0, 4'd0, 16'h0000, 1, 4'd2, 16'h2003, 0, 4'd0, 4'd1, 4'd2, 0};
        tbl[9]  = '{0, 4'd0, 16'h0000, 1, 4'd2, 16'h2003, 0, 4'd0, 4'd1, 4'd2, 1};
        tbl[10] = '{0, 4'd0, 16'h0000, 1, 4'd2, 16'h2004, 0, 4'd0, 4'd1, 4'd2, 1};
        tbl[11] = idle;
        tbl[12] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd7, 4'd7, 4'd13, 1};
        tbl[13] = '{0, 4'd0, 16'h0000, 1, 4'd7, 16'h7777, 0, 4'd0, 4'd7, 4'd13, 1};
        tbl[14] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd7, 4'd7, 4'd13, 1};
        tbl[15] = '{0, 4'd0, 16'h0000, 1, 4'd7, 16'h7778, 0, 4'd0, 4'd7, 4'd13, 1};
        tbl[16] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd7, 4'd13, 1};
        tbl[17] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd7, 4'd13, 1};
        tbl[18] = '{0, 4'd0, 16'h0000, 1, 4'd13, 16'hDEAD, 0, 4'd0, 4'd7, 4'd13, 1};
        tbl[19] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd14, 4'd7, 4'd14, 1};
        tbl[20] = '{1, 4'd11, 16'hBBBB, 1, 4'd15, 16'hBEEF, 0, 4'd0, 4'd11, 4'd14, 1};
        tbl[21] = '{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd11, 4'd14, 1};
        tbl[22] = idle;

        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        check("reset_wre", u_if.wre, 1'b0);
        check("reset_alu_ready", u_if.alu_ready, 1'b1);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i]);
            check($sformatf("alu_ready_vec%0d", i), u_if.alu_ready, tbl[i].exp_ready);
            @(posedge clk);
            #1;
        end

        // Fill the buffer and set pending bits, then reset asynchronously mid-cycle
        drive('{1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202, 1, 4'd8, 4'd8, 4'd9, 1});
        @(posedge clk); #1;
        drive('{1, 4'd1, 16'h0102, 1, 4'd3, 16'h0303, 1, 4'd9, 4'd8, 4'd9, 1});
        @(posedge clk); #1;
        drive('{1, 4'd1, 16'h0103, 1, 4'd4, 16'h0404, 0, 4'd0, 4'd8, 4'd9, 0});
        check("full_alu_ready", u_if.alu_ready, 1'b0);
        check("pre_reset_wre", u_if.wre, 1'b1);
        check("pre_reset_busy1", u_if.q_busy1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_wre", u_if.wre, 1'b0);
        check("async_a3", u_if.a3, 4'd0);
        check("async_wd3", u_if.wd3, 16'h0000);
        check("async_busy1", u_if.q_busy1, 1'b0);
        check("async_busy2", u_if.q_busy2, 1'b0);
        check("async_alu_ready", u_if.alu_ready, 1'b1);
        drive('{0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd8, 4'd9, 1});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_busy1", u_if.q_busy1, 1'b0);
        check("post_reset_ready", u_if.alu_ready, 1'b1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
